// File: rtl/spi_pkg.sv
// Shared types and constants for the mode-0 SPI master.
package spi_pkg;

  localparam int unsigned SPI_BITS  = 8;
  localparam int unsigned BIT_CNT_W = $clog2(SPI_BITS);

  // Mode 0 polarities
  localparam logic SCK_IDLE      = 1'b0;
  localparam logic SSEL_ACTIVE   = 1'b0;
  localparam logic SSEL_INACTIVE = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StXfer,
    StNext,
    StHold,
    StGap
  } spi_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SCK half-period divider: emits rise/fall strobes one cycle ahead of the SCK level change.
module spi_sck_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sck,
  output logic sck_rise,
  output logic sck_fall
);
  import spi_pkg::*;

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_q;
  logic             sck_q;
  logic             wrap;

  assign wrap = en && (div_q == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      sck_q <= SCK_IDLE;
    end else if (!en) begin
      div_q <= '0;
      sck_q <= SCK_IDLE;
    end else if (wrap) begin
      div_q <= '0;
      sck_q <= ~sck_q;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  assign sck      = sck_q;
  assign sck_rise = wrap && (sck_q == SCK_IDLE);
  assign sck_fall = wrap && (sck_q != SCK_IDLE);

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master, MSB first, multi-byte transactions under one SSEL.
// Define SPI_MASTER_LOOPBACK_EN to feed MOSI back as the MISO source for self-test.
module spi_master #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned SETUP_CYC = 8,
  parameter int unsigned GAP_CYC   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       sck,
  output logic       mosi,
  input  logic       miso,
  output logic       ssel
);
  import spi_pkg::*;

  localparam int unsigned CNT_W = $clog2(max_u(SETUP_CYC, GAP_CYC) + 1);

  spi_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BIT_CNT_W-1:0]  bit_q, bit_d;
  logic [SPI_BITS-1:0]   tx_sr_q, tx_sr_d;
  logic [SPI_BITS-1:0]   rx_sr_q, rx_sr_d;
  logic [SPI_BITS-1:0]   rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  last_q, last_d;
  logic                  ssel_q, ssel_d;
  logic                  rdy_en_q;
  logic                  miso_s1_q, miso_s2_q;
  logic                  miso_src;
  logic                  sck_en, sck_rise, sck_fall;
  logic                  accept;

`ifdef SPI_MASTER_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = miso;
  assign miso_src    = tx_sr_q[SPI_BITS-1];
`else
  assign miso_src = miso;
`endif

  assign sck_en = (state_q == StXfer);

  spi_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (sck_en),
    .sck      (sck),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall)
  );

  // Ready is held off for one clock after reset release
  assign tx_ready = rdy_en_q && ((state_q == StIdle) || (state_q == StNext && !last_q));
  assign accept   = tx_valid && tx_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    last_d     = last_q;
    ssel_d     = ssel_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          tx_sr_d = tx_data;
          last_d  = tx_last;
          ssel_d  = SSEL_ACTIVE;
          cnt_d   = '0;
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
          cnt_d   = '0;
          state_d = StXfer;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StXfer: begin
        if (sck_rise) begin
          rx_sr_d = {rx_sr_q[SPI_BITS-2:0], miso_s2_q};
        end
        if (sck_fall) begin
          tx_sr_d = {tx_sr_q[SPI_BITS-2:0], 1'b0};
          bit_d   = bit_q + 1'b1;
          if (bit_q == BIT_CNT_W'(SPI_BITS - 1)) begin
            rx_data_d  = rx_sr_q;
            rx_valid_d = 1'b1;
            state_d    = StNext;
          end
        end
      end
      StNext: begin
        if (last_q) begin
          cnt_d   = '0;
          state_d = StHold;
        end else if (accept) begin
          tx_sr_d = tx_data;
          last_d  = tx_last;
          state_d = StXfer;
        end
      end
      StHold: begin
        if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
          cnt_d   = '0;
          ssel_d  = SSEL_INACTIVE;
          state_d = StGap;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StGap: begin
        if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_q      <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      last_q     <= 1'b0;
      ssel_q     <= SSEL_INACTIVE;
      rdy_en_q   <= 1'b0;
      miso_s1_q  <= 1'b0;
      miso_s2_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      last_q     <= last_d;
      ssel_q     <= ssel_d;
      rdy_en_q   <= 1'b1;
      miso_s1_q  <= miso_src;
      miso_s2_q  <= miso_s1_q;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = (state_q != StIdle);
  assign mosi     = tx_sr_q[SPI_BITS-1];
  assign ssel     = ssel_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master with a mode-0 slave model and RX/MOSI scoreboards.
module tb_spi_master;
  localparam int unsigned CLK_DIV   = 4;
  localparam int unsigned SETUP_CYC = 8;
  localparam int unsigned GAP_CYC   = 8;
  localparam int          TMO       = 5000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_last = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       sck;
  logic       mosi;
  logic       miso = 1'b0;
  logic       ssel;

  spi_master #(
    .CLK_DIV   (CLK_DIV),
    .SETUP_CYC (SETUP_CYC),
    .GAP_CYC   (GAP_CYC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_last  (tx_last),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy),
    .sck      (sck),
    .mosi     (mosi),
    .miso     (miso),
    .ssel     (ssel)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_rx_q[$];
  logic [7:0] exp_mosi_q[$];
  logic [7:0] slave_resp[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Timing monitor and RX scoreboard, sampled on the inactive clock edge
  int   cyc = 0, sck_rises = 0, ssel_rises = 0, rx_count = 0;
  int   t_ssel_fall = 0, t_ssel_rise = 0, t_last_rise = 0, t_last_fall = 0;
  int   first_rise_lat = 0, max_rr = 0, gap = 0, hold_len = 0;
  bit   rise_pending = 1'b0;
  logic ssel_p = 1'b1, sck_p = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (ssel_p && !ssel) begin
      t_ssel_fall  = cyc;
      gap          = cyc - t_ssel_rise;
      rise_pending = 1'b1;
      max_rr       = 0;
    end
    if (!ssel_p && ssel) begin
      t_ssel_rise = cyc;
      hold_len    = cyc - t_last_fall;
      ssel_rises++;
    end
    if (!sck_p && sck) begin
      sck_rises++;
      if (rise_pending) begin
        first_rise_lat = cyc - t_ssel_fall;
        rise_pending   = 1'b0;
      end else if (cyc - t_last_rise > max_rr) begin
        max_rr = cyc - t_last_rise;
      end
      t_last_rise = cyc;
    end
    if (sck_p && !sck) t_last_fall = cyc;
    ssel_p = ssel;
    sck_p  = sck;
    if (rst_n && rx_valid) begin
      rx_count++;
      check("rx_expected_pending", 32'(exp_rx_q.size() != 0), 32'd1);
      if (exp_rx_q.size() != 0) check("rx_data", 32'(rx_data), 32'(exp_rx_q.pop_front()));
    end
  end

  // Mode-0 slave: MISO changes on SCK fall / SSEL fall, MOSI captured on SCK rise
  logic       ssel_m = 1'b1, sck_m = 1'b0;
  logic [7:0] s_cur = 8'h00, s_cap = 8'h00;
  int         s_pos = 0, s_bits = 0;

  always @(ssel or sck) begin
    if (!ssel && ssel_m) begin
      s_pos  = 0;
      s_bits = 0;
      s_cur  = (slave_resp.size() > 0) ? slave_resp[0] : 8'h00;
      miso   = s_cur[7];
    end else if (!ssel && sck && !sck_m) begin
      s_cap = {s_cap[6:0], mosi};
      s_bits++;
      if (s_bits == 8) begin
        s_bits = 0;
        check("mosi_expected_pending", 32'(exp_mosi_q.size() != 0), 32'd1);
        if (exp_mosi_q.size() != 0) check("mosi_byte", 32'(s_cap), 32'(exp_mosi_q.pop_front()));
      end
    end else if (!ssel && !sck && sck_m) begin
      if (s_bits == 0) begin
        s_pos++;
        s_cur = (s_pos < slave_resp.size()) ? slave_resp[s_pos] : 8'h00;
      end else begin
        s_cur = {s_cur[6:0], 1'b0};
      end
      miso = s_cur[7];
    end
    ssel_m = ssel;
    sck_m  = sck;
  end

  task automatic send(input logic [7:0] d, input logic l, input logic [7:0] s);
    int n = 0;
    exp_mosi_q.push_back(d);
`ifdef SPI_MASTER_LOOPBACK_EN
    exp_rx_q.push_back(d);
`else
    exp_rx_q.push_back(s);
`endif
    tx_data  = d;
    tx_valid = 1'b1;
    tx_last  = l;
    while (!tx_ready && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (n >= TMO) check("send_ready_timeout", 32'(tx_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while (busy && n < TMO) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, s0, e0, n, bad;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_ssel", 32'(ssel), 32'd1);
    check("rst_sck", 32'(sck), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'h00);
    check("rst_tx_ready", 32'(tx_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    check("ready_before_first_clk", 32'(tx_ready), 32'd0);
    @(posedge clk);
    #1;
    check("ready_after_first_clk", 32'(tx_ready), 32'd1);

    // Single byte A5, slave returns 3C
    slave_resp = '{8'h3C};
    r0 = rx_count; s0 = sck_rises; e0 = ssel_rises;
    send(8'hA5, 1'b1, 8'h3C);
    tx_valid = 1'b0;
    wait_idle("t2");
    check("t2_rx_strobes", 32'(rx_count - r0), 32'd1);
    check("t2_sck_pulses", 32'(sck_rises - s0), 32'd8);
    check("t2_ssel_to_sck", 32'(first_rise_lat), 32'(SETUP_CYC + CLK_DIV));
    check("t2_sck_period", 32'(max_rr), 32'(2 * CLK_DIV));
    check("t2_ssel_high", 32'(ssel), 32'd1);
    check("t2_ssel_rises", 32'(ssel_rises - e0), 32'd1);
    check("t2_hold_len", 32'(hold_len >= int'(SETUP_CYC)), 32'd1);

    // Three bytes back-to-back with tx_valid held high
    slave_resp = '{8'hC3, 8'h5A, 8'h99};
    r0 = rx_count; s0 = sck_rises; e0 = ssel_rises;
    send(8'h01, 1'b0, 8'hC3);
    send(8'h02, 1'b0, 8'h5A);
    send(8'h03, 1'b1, 8'h99);
    tx_valid = 1'b0;
    wait_idle("t3");
    check("t3_gap", 32'(gap >= int'(GAP_CYC)), 32'd1);
    check("t3_sck_pulses", 32'(sck_rises - s0), 32'd24);
    check("t3_rx_strobes", 32'(rx_count - r0), 32'd3);
    check("t3_no_ssel_gap", 32'(ssel_rises - e0), 32'd1);
    check("t3_no_sck_idle", 32'(max_rr <= int'(2 * CLK_DIV + 1)), 32'd1);

    // Stall between bytes
    slave_resp = '{8'h81, 8'h7E};
    r0 = rx_count; s0 = sck_rises; e0 = ssel_rises;
    send(8'h55, 1'b0, 8'h81);
    tx_valid = 1'b0;
    n = 0;
    while (rx_count == r0 && n < TMO) begin
      @(negedge clk);
      n++;
    end
    check("t4_first_rx", 32'(rx_count - r0), 32'd1);
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (ssel !== 1'b0 || sck !== 1'b0 || tx_ready !== 1'b1) bad++;
    end
    check("t4_stall_hold", 32'(bad), 32'd0);
    send(8'h96, 1'b1, 8'h7E);
    tx_valid = 1'b0;
    wait_idle("t4");
    check("t4_gap", 32'(gap >= int'(GAP_CYC)), 32'd1);
    check("t4_sck_pulses", 32'(sck_rises - s0), 32'd16);
    check("t4_rx_strobes", 32'(rx_count - r0), 32'd2);
    check("t4_ssel_rises", 32'(ssel_rises - e0), 32'd1);

    // CE, AA (loopback builds expect the TX bytes back)
    slave_resp = '{8'h12, 8'h34};
    send(8'hCE, 1'b0, 8'h12);
    send(8'hAA, 1'b1, 8'h34);
    tx_valid = 1'b0;
    wait_idle("t6");

    // Reset mid-transfer
    slave_resp = '{8'hF0};
    s0 = sck_rises;
    send(8'h3C, 1'b1, 8'hF0);
    tx_valid = 1'b0;
    n = 0;
    while (sck_rises == s0 && n < TMO) begin
      @(negedge clk);
      n++;
    end
    check("t1_reached_xfer", 32'(sck_rises > s0), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_ssel", 32'(ssel), 32'd1);
    check("midrst_sck", 32'(sck), 32'd0);
    check("midrst_mosi", 32'(mosi), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_rx_valid", 32'(rx_valid), 32'd0);
    check("midrst_tx_ready", 32'(tx_ready), 32'd0);
    exp_rx_q.delete();
    exp_mosi_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Recovery transaction
    slave_resp = '{8'h6B};
    r0 = rx_count;
    send(8'hD2, 1'b1, 8'h6B);
    tx_valid = 1'b0;
    wait_idle("rec");
    check("rec_rx_strobes", 32'(rx_count - r0), 32'd1);

    check("rx_queue_drained", 32'(exp_rx_q.size()), 32'd0);
    check("mosi_queue_drained", 32'(exp_mosi_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
